// File: rtl/c499_lock_seq.sv
// Sequencer for the key-locked c499 SEC datapath: serial key load with atomic
// commit, valid/ready input apply, programmable settle, held output capture.
module c499_lock_seq #(
  parameter int KEY_W      = 10,
  parameter int DIN_W      = 41,
  parameter int DOUT_W     = 32,
  parameter int SETTLE_CYC = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              key_valid,
  input  logic              key_bit,
  input  logic              key_clear,
  output logic              key_ready,
  output logic              key_loaded,
  output logic [KEY_W-1:0]  key_out,
  input  logic              in_valid,
  input  logic [DIN_W-1:0]  in_data,
  output logic              in_ready,
  output logic [DIN_W-1:0]  ckt_in,
  input  logic [DOUT_W-1:0] ckt_out,
  output logic              out_valid,
  output logic [DOUT_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic [15:0]       done_cnt,
  output logic [1:0]        state_dbg
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on the same channel's valid, and out_valid
  // with out_data stays stable until taken.

  typedef enum logic [1:0] {IDLE, KSHIFT, SETTLE, HOLD} state_t;

  localparam int CW = $clog2(KEY_W + 1);
  localparam int SW = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [CW-1:0] LAST_BIT    = CW'(KEY_W - 1);
  localparam logic [SW-1:0] SETTLE_INIT = SW'(SETTLE_CYC - 1);

  state_t           state, state_nx;
  logic [KEY_W-1:0] shadow;
  logic [CW-1:0]    bit_cnt;
  logic [SW-1:0]    settle_cnt;

  logic shift_en, commit, key_abort, accept, capture, retire;

  always_comb begin
    state_nx  = state;
    shift_en  = 1'b0;
    commit    = 1'b0;
    key_abort = 1'b0;
    accept    = 1'b0;
    capture   = 1'b0;
    retire    = 1'b0;
    key_ready = ((state == IDLE) || (state == KSHIFT)) && !key_clear;
    in_ready  = (state == IDLE) && key_loaded && !key_valid;
    case (state)
      IDLE: begin
        if (key_valid && key_ready) begin
          shift_en = 1'b1;
          state_nx = KSHIFT;
        end else if (in_valid && in_ready) begin
          accept   = 1'b1;
          state_nx = SETTLE;
        end
      end
      KSHIFT: begin
        if (key_clear) begin
          key_abort = 1'b1;
          state_nx  = IDLE;
        end else if (key_valid) begin
          shift_en = 1'b1;
          if (bit_cnt == LAST_BIT) begin
            commit   = 1'b1;
            state_nx = IDLE;
          end
        end
      end
      SETTLE: begin
        if (settle_cnt == '0) begin
          capture  = 1'b1;
          state_nx = HOLD;
        end
      end
      HOLD: begin
        if (out_ready) begin
          retire   = 1'b1;
          state_nx = IDLE;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      shadow     <= '0;
      bit_cnt    <= '0;
      key_out    <= '0;
      key_loaded <= 1'b0;
      ckt_in     <= '0;
      settle_cnt <= '0;
      out_data   <= '0;
      out_valid  <= 1'b0;
      done_cnt   <= '0;
    end else begin
      state <= state_nx;

      if (key_abort)     shadow <= '0;
      else if (shift_en) shadow <= {shadow[KEY_W-2:0], key_bit};

      if (key_abort || commit) bit_cnt <= '0;
      else if (shift_en)       bit_cnt <= bit_cnt + 1'b1;

      // The committed key includes the bit arriving on this same edge.
      if (commit) begin
        key_out    <= {shadow[KEY_W-2:0], key_bit};
        key_loaded <= 1'b1;
      end

      if (accept) begin
        ckt_in     <= in_data;
        settle_cnt <= SETTLE_INIT;
      end else if ((state == SETTLE) && (settle_cnt != '0)) begin
        settle_cnt <= settle_cnt - 1'b1;
      end

      if (capture) begin
        out_data  <= ckt_out;
        out_valid <= 1'b1;
      end else if (retire) begin
        out_valid <= 1'b0;
        done_cnt  <= done_cnt + 16'd1;
      end
    end
  end

  assign busy      = (state != IDLE);
  assign state_dbg = state;

endmodule
